// File: rtl/uart_tx_fifo.sv
// UART transmitter framing words from an internal FIFO; uart_tx is registered, first start bit 2 cycles after the push edge.
// Backpressure: tx_ready low while the FIFO is full; uart_en only gates the start of new frames, never truncates one.

module uart_tx_fifo_buf #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    output logic          push_rdy,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   count
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (count != (AW+1)'(DEPTH));
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop && (count != '0);
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (!do_push && do_pop)
                count <= count - (AW+1)'(1);
        end
    end
endmodule

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_AW      = 2
) (
    input  logic                 uart_clk,
    input  logic                 uart_rst,
    input  logic                 uart_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    output logic                 tx_busy,
    output logic [FIFO_AW:0]     fifo_count
);
    localparam int   BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int   BIT_W  = $clog2(DATA_BITS);
    localparam logic ODD    = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  par_bit;
    logic [DATA_BITS-1:0]  head;
    logic                  pop;
    logic                  baud_tc;

    assign pop     = (state == S_IDLE) && uart_en && (fifo_count != '0);
    assign baud_tc = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign tx_busy = (state != S_IDLE);

    uart_tx_fifo_buf #(
        .W  (DATA_BITS),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (uart_clk),
        .rst      (uart_rst),
        .push_vld (tx_valid),
        .push_rdy (tx_ready),
        .push_dat (tx_data),
        .pop      (pop),
        .pop_dat  (head),
        .count    (fifo_count)
    );

    // Line level is registered from the current state, so it trails the state by one cycle.
    always_ff @(posedge uart_clk) begin
        if (uart_rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    uart_tx  <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (pop) begin
                        shreg   <= head;
                        par_bit <= (^head) ^ ODD;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    uart_tx <= 1'b0;
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    uart_tx <= shreg[0];
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_PARITY: begin
                    uart_tx <= par_bit;
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    uart_tx <= 1'b1;
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_W'(STOP_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule
